// File: rtl/vx_data_flush.sv
// Per-bank flush engine: walks every line of the bank in index order, writes back dirty
// lines as full-line memory requests and clears their dirty bits.
module vx_data_flush #(
   parameter int CACHE_ID        = 0,
   parameter int BANK_ID         = 0,
   parameter int CACHE_SIZE      = 16384,
   parameter int CACHE_LINE_SIZE = 64,
   parameter int NUM_BANKS       = 4,
   parameter int WORD_SIZE       = 4,
   parameter int TAG_WIDTH       = 32 - $clog2(CACHE_LINE_SIZE)
                                   - ((CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS) > 1)
                                      ? $clog2(CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS)) : 1),
   localparam int LINES_PER_BANK   = CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS),
   localparam int LINE_SELECT_BITS = (LINES_PER_BANK > 1) ? $clog2(LINES_PER_BANK) : 1,
   localparam int CACHE_LINE_WIDTH = 8 * CACHE_LINE_SIZE,
   localparam int LINE_ADDR_WIDTH  = TAG_WIDTH + LINE_SELECT_BITS
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        flush_start,
   output logic                        flush_busy,
   output logic                        flush_done,
   input  logic                        ds_grant,
   output logic                        ds_readen,
   output logic [LINE_SELECT_BITS-1:0] ds_addr,
   input  logic [CACHE_LINE_WIDTH-1:0] ds_rdata,
   input  logic [TAG_WIDTH-1:0]        line_tag,
   input  logic                        line_dirty,
   output logic                        clr_valid,
   output logic [LINE_SELECT_BITS-1:0] clr_addr,
   output logic                        mem_req_valid,
   output logic [LINE_ADDR_WIDTH-1:0]  mem_req_addr,
   output logic [CACHE_LINE_WIDTH-1:0] mem_req_data,
   input  logic                        mem_req_ready
);

   if (CACHE_ID < 0 || BANK_ID < 0 || BANK_ID >= NUM_BANKS || LINES_PER_BANK < 1
       || (CACHE_LINE_SIZE % WORD_SIZE) != 0) begin : g_bad_cfg
      $error("vx_data_flush: invalid configuration");
   end

   localparam logic [LINE_SELECT_BITS-1:0] LastIdx = LINE_SELECT_BITS'(LINES_PER_BANK - 1);

   typedef enum logic [2:0] {StIdle, StRead, StCapt, StSend, StDone} state_e;

   state_e                      state_q, state_d;
   logic [LINE_SELECT_BITS-1:0] index_q, index_d;
   logic [TAG_WIDTH-1:0]        tag_q;
   logic [CACHE_LINE_WIDTH-1:0] data_q;
   logic                        capture;
   logic                        advance;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         index_q <= '0;
         tag_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         if (capture) begin
            tag_q  <= line_tag;
            data_q <= ds_rdata;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      index_d       = index_q;
      capture       = 1'b0;
      advance       = 1'b0;
      flush_done    = 1'b0;
      ds_readen     = 1'b0;
      clr_valid     = 1'b0;
      mem_req_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (flush_start) begin
               index_d = '0;
               state_d = StRead;
            end
         end
         StRead: begin
            ds_readen = ds_grant;
            if (ds_grant) state_d = StCapt;
         end
         StCapt: begin
            capture = 1'b1;
            if (line_dirty) state_d = StSend;
            else            advance = 1'b1;
         end
         StSend: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               clr_valid = 1'b1;
               advance   = 1'b1;
            end
         end
         StDone: begin
            flush_done = 1'b1;
            index_d    = '0;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // Shared line-advance path for a clean capture and an accepted writeback.
      if (advance) begin
         if (index_q == LastIdx) begin
            state_d = StDone;
         end else begin
            index_d = index_q + 1'b1;
            state_d = StRead;
         end
      end
   end

   assign flush_busy   = (state_q != StIdle);
   assign ds_addr      = index_q;
   assign clr_addr     = index_q;
   assign mem_req_addr = {tag_q, index_q};
   assign mem_req_data = data_q;

endmodule

// File: tb/tb_vx_data_flush.sv
// Self-checking bench for vx_data_flush: a line-store model answers reads, and each scenario
// compares the observed read/writeback/clear traffic against what the store contents dictate.
module tb_vx_data_flush;
   localparam int CacheSize = 1024;
   localparam int LineSize  = 64;
   localparam int Banks     = 4;
   localparam int N         = 4;
   localparam int Sel       = 2;
   localparam int LW        = 512;
   localparam int TagW      = 24;
   localparam int LAW       = 26;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            flush_start = 1'b0;
   logic            ds_grant = 1'b0;
   logic            mem_req_ready = 1'b0;
   logic            flush_busy, flush_done, ds_readen, clr_valid, mem_req_valid;
   logic [Sel-1:0]  ds_addr, clr_addr;
   logic [LW-1:0]   ds_rdata;
   logic [TagW-1:0] line_tag;
   logic            line_dirty;
   logic [LAW-1:0]  mem_req_addr;
   logic [LW-1:0]   mem_req_data;

   always #5 clk = ~clk;

   vx_data_flush #(
      .CACHE_SIZE      (CacheSize),
      .CACHE_LINE_SIZE (LineSize),
      .NUM_BANKS       (Banks)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .flush_start   (flush_start),
      .flush_busy    (flush_busy),
      .flush_done    (flush_done),
      .ds_grant      (ds_grant),
      .ds_readen     (ds_readen),
      .ds_addr       (ds_addr),
      .ds_rdata      (ds_rdata),
      .line_tag      (line_tag),
      .line_dirty    (line_dirty),
      .clr_valid     (clr_valid),
      .clr_addr      (clr_addr),
      .mem_req_valid (mem_req_valid),
      .mem_req_addr  (mem_req_addr),
      .mem_req_data  (mem_req_data),
      .mem_req_ready (mem_req_ready)
   );

   // Line store model: returns the addressed line one cycle after a read, garbage otherwise.
   logic [LW-1:0]   st_data  [N];
   logic [TagW-1:0] st_tag   [N];
   logic            st_dirty [N];

   always @(posedge clk) begin
      if (ds_readen) begin
         ds_rdata   <= st_data[ds_addr];
         line_tag   <= st_tag[ds_addr];
         line_dirty <= st_dirty[ds_addr];
      end else begin
         ds_rdata   <= {16{$urandom}};
         line_tag   <= TagW'($urandom);
         line_dirty <= 1'($urandom);
      end
   end

   int errors = 0;
   int checks = 0;

   int             rd_idx [$];
   int             rd_rel [$];
   logic [LAW-1:0] wb_addr [$];
   logic [LW-1:0]  wb_data [$];
   int             clr_log [$];
   int  rel, done_cnt, done_rel, stalls, stab_viol, ahead_viol, clr_viol, busy_gap, post_busy;
   int  glo_from = -1, glo_to = -2, start_at_rel = -1, ready_low_left = 0;
   bit  grant_rand = 1'b0, ready_rand = 1'b0, start_on_done = 1'b0;
   logic           prev_stall;
   logic [LAW-1:0] prev_addr;
   logic [LW-1:0]  prev_data;

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] d;
      for (int w = 0; w < LW / 32; w++) d[w*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic fill_store(input bit random_dirty);
      for (int i = 0; i < N; i++) begin
         st_data[i]  = rand_line();
         st_tag[i]   = TagW'($urandom);
         st_dirty[i] = random_dirty ? 1'($urandom) : 1'b0;
      end
   endtask

   function automatic int dirty_count();
      int c = 0;
      for (int i = 0; i < N; i++) if (st_dirty[i]) c++;
      return c;
   endfunction

   // Model: every line read exactly once, in index order.
   function automatic bit reads_ok();
      if (rd_idx.size() != N) return 1'b0;
      for (int i = 0; i < N; i++) if (rd_idx[i] != i) return 1'b0;
      return 1'b1;
   endfunction

   // Model: one writeback {tag, index}/data per dirty line, in index order.
   function automatic bit wb_ok();
      int j = 0;
      logic [Sel-1:0] ii;
      for (int i = 0; i < N; i++) begin
         if (st_dirty[i]) begin
            ii = Sel'(i);
            if (j >= wb_addr.size()) return 1'b0;
            if (wb_addr[j] !== {st_tag[i], ii} || wb_data[j] !== st_data[i]) return 1'b0;
            j++;
         end
      end
      return j == wb_addr.size();
   endfunction

   function automatic bit clr_ok();
      int j = 0;
      for (int i = 0; i < N; i++) begin
         if (st_dirty[i]) begin
            if (j >= clr_log.size() || clr_log[j] != i) return 1'b0;
            j++;
         end
      end
      return j == clr_log.size();
   endfunction

   task automatic clear_log();
      rd_idx.delete(); rd_rel.delete(); wb_addr.delete(); wb_data.delete(); clr_log.delete();
      rel = 0; done_cnt = 0; done_rel = -1; stalls = 0; stab_viol = 0; ahead_viol = 0;
      clr_viol = 0; busy_gap = 0; post_busy = 0; prev_stall = 1'b0;
   endtask

   // One cycle: drive inputs just after the falling edge, then observe and log.
   task automatic step();
      @(negedge clk);
      rel++;
      flush_start   = (start_at_rel >= 0 && rel == start_at_rel);
      ds_grant      = (rel >= glo_from && rel <= glo_to) ? 1'b0 :
                      (grant_rand ? ($urandom_range(9) < 7) : 1'b1);
      mem_req_ready = (ready_low_left > 0) ? 1'b0 :
                      (ready_rand ? ($urandom_range(9) < 6) : 1'b1);
      #1;
      if (ds_readen) begin
         rd_idx.push_back(int'(ds_addr));
         rd_rel.push_back(rel);
         if (mem_req_valid) ahead_viol++;
      end
      if (mem_req_valid) begin
         if (prev_stall && (mem_req_addr !== prev_addr || mem_req_data !== prev_data))
            stab_viol++;
         if (!mem_req_ready) stalls++;
         else begin
            wb_addr.push_back(mem_req_addr);
            wb_data.push_back(mem_req_data);
         end
      end
      prev_stall = mem_req_valid && !mem_req_ready;
      prev_addr  = mem_req_addr;
      prev_data  = mem_req_data;
      if (clr_valid) begin
         clr_log.push_back(int'(clr_addr));
         if (!(mem_req_valid && mem_req_ready)) clr_viol++;
      end
      if (done_cnt == 0 && !flush_busy) busy_gap++;
      if (done_cnt > 0 && flush_busy) post_busy++;
      if (flush_done) begin
         done_cnt++;
         done_rel = rel;
      end
      if (mem_req_valid && !mem_req_ready && ready_low_left > 0) ready_low_left--;
      if (start_on_done && flush_done) flush_start = 1'b1;
   endtask

   task automatic run_flush(input int max_cycles, input int tail, output bit timed_out);
      clear_log();
      @(negedge clk);
      flush_start = 1'b1;
      ds_grant    = 1'b1;
      #1;
      while (done_cnt == 0 && rel < max_cycles) step();
      timed_out = (done_cnt == 0);
      repeat (tail) step();
   endtask

   task automatic test_reset();
      logic [4:0] ctl;
      reset = 1'b1; ds_grant = 1'b1; mem_req_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      ctl = {flush_busy, flush_done, ds_readen, clr_valid, mem_req_valid};
      checks++;
      if (ctl !== 5'b0) begin
         errors++; $display("FAIL reset_ctl: got %b want 00000", ctl);
      end
      checks++;
      if ({ds_addr, clr_addr, mem_req_addr} !== '0 || mem_req_data !== '0) begin
         errors++;
         $display("FAIL reset_data: got ds_addr=%0d clr_addr=%0d addr=%h want all zero",
                  ds_addr, clr_addr, mem_req_addr);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_clean();
      bit to;
      fill_store(1'b0);
      run_flush(100, 3, to);
      checks++;
      if (to || !reads_ok()) begin
         errors++; $display("FAIL clean_reads: got %0d reads timeout=%0d want %0d", rd_idx.size(), to, N);
      end
      checks++;
      if (rd_rel.size() != N || rd_rel[0] != 1 || rd_rel[1] != 3 || rd_rel[2] != 5 || rd_rel[3] != 7) begin
         errors++; $display("FAIL clean_read_timing: got %p want 1 3 5 7", rd_rel);
      end
      checks++;
      if (wb_addr.size() != 0) begin
         errors++; $display("FAIL clean_no_wb: got %0d requests want 0", wb_addr.size());
      end
      // Two cycles per clean line after the accepting edge, then the done cycle.
      checks++;
      if (done_rel != 2 * N + 1) begin
         errors++; $display("FAIL clean_done_latency: got %0d want %0d", done_rel, 2 * N + 1);
      end
      checks++;
      if (busy_gap != 0 || done_cnt != 1) begin
         errors++; $display("FAIL clean_busy: got gap=%0d done=%0d want 0 and 1", busy_gap, done_cnt);
      end
   endtask

   task automatic test_dirty_line2();
      bit to;
      fill_store(1'b0);
      st_dirty[2] = 1'b1;
      st_tag[2]   = 24'h0001A5;
      st_data[2]  = {16{32'hDEADBEEF}};
      run_flush(100, 3, to);
      checks++;
      if (to || wb_addr.size() != 1 || wb_addr[0] !== {24'h0001A5, 2'd2}) begin
         errors++;
         $display("FAIL dirty2_addr: got n=%0d addr=%h want 1 x %h", wb_addr.size(),
                  (wb_addr.size() > 0) ? wb_addr[0] : '0, {24'h0001A5, 2'd2});
      end
      checks++;
      if (!wb_ok()) begin
         errors++; $display("FAIL dirty2_data: got n=%0d want data DEADBEEF x16", wb_data.size());
      end
      checks++;
      if (clr_log.size() != 1 || clr_log[0] != 2 || clr_viol != 0) begin
         errors++; $display("FAIL dirty2_clr: got %p viol=%0d want [2] viol=0", clr_log, clr_viol);
      end
      checks++;
      if (done_rel != 2 * N + 2) begin
         errors++; $display("FAIL dirty2_latency: got %0d want %0d", done_rel, 2 * N + 2);
      end
   endtask

   task automatic test_backpressure();
      bit to;
      fill_store(1'b0);
      st_dirty[1]    = 1'b1;
      ready_low_left = 5;
      run_flush(100, 3, to);
      checks++;
      if (to || stalls != 5 || stab_viol != 0) begin
         errors++; $display("FAIL bp_stable: got stalls=%0d unstable=%0d want 5 and 0", stalls, stab_viol);
      end
      checks++;
      if (ahead_viol != 0 || !reads_ok()) begin
         errors++; $display("FAIL bp_no_readahead: got %0d reads during request want 0", ahead_viol);
      end
      checks++;
      if (!wb_ok() || !clr_ok()) begin
         errors++; $display("FAIL bp_writeback: got n=%0d clr=%p want one for line 1", wb_addr.size(), clr_log);
      end
      checks++;
      if (done_rel != 2 * N + 2 + 5) begin
         errors++; $display("FAIL bp_latency: got %0d want %0d", done_rel, 2 * N + 7);
      end
   endtask

   task automatic test_grant_gap();
      bit to;
      fill_store(1'b0);
      // Grant drops during CAPT of line 0 (no effect) and the first 3 READ cycles of line 1.
      glo_from = 2; glo_to = 5;
      run_flush(100, 3, to);
      glo_from = -1; glo_to = -2;
      checks++;
      if (to || !reads_ok() || rd_rel[1] != 6) begin
         errors++; $display("FAIL grant_gap_read: got reads=%p at %p want idx1 at 6", rd_idx, rd_rel);
      end
      checks++;
      if (done_rel != 2 * N + 1 + 3) begin
         errors++; $display("FAIL grant_gap_latency: got %0d want %0d", done_rel, 2 * N + 4);
      end
   endtask

   task automatic test_restart_ignored();
      bit to;
      fill_store(1'b0);
      start_at_rel = 4; start_on_done = 1'b1;
      run_flush(100, 4, to);
      start_at_rel = -1; start_on_done = 1'b0;
      checks++;
      if (to || done_cnt != 1 || post_busy != 0) begin
         errors++; $display("FAIL restart_ignored: got done=%0d busy_after=%0d want 1 and 0", done_cnt, post_busy);
      end
      checks++;
      if (!reads_ok() || done_rel != 2 * N + 1) begin
         errors++; $display("FAIL restart_reads: got n=%0d done_at=%0d want %0d and %0d", rd_idx.size(), done_rel, N, 2 * N + 1);
      end
   endtask

   task automatic test_reset_in_send();
      bit to;
      int n = 0;
      fill_store(1'b0);
      st_dirty[0]    = 1'b1;
      ready_low_left = 1000;
      clear_log();
      @(negedge clk);
      flush_start = 1'b1;
      ds_grant    = 1'b1;
      #1;
      while (!mem_req_valid && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (!mem_req_valid) begin
         errors++; $display("FAIL rst_send_reach: got valid=%b want 1 within 20 cycles", mem_req_valid);
      end
      reset = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (mem_req_valid !== 1'b0 || flush_busy !== 1'b0 || clr_valid !== 1'b0 || mem_req_addr !== '0) begin
         errors++;
         $display("FAIL rst_send_outputs: got valid=%b busy=%b clr=%b addr=%h want 0 0 0 0",
                  mem_req_valid, flush_busy, clr_valid, mem_req_addr);
      end
      checks++;
      if (clr_log.size() != 0 || wb_addr.size() != 0) begin
         errors++; $display("FAIL rst_send_dropped: got clr=%0d wb=%0d want 0 0", clr_log.size(), wb_addr.size());
      end
      @(negedge clk);
      reset = 1'b0;
      ready_low_left = 0;
      fill_store(1'b0);
      run_flush(100, 2, to);
      checks++;
      if (to || !reads_ok() || done_cnt != 1 || done_rel != 2 * N + 1) begin
         errors++; $display("FAIL rst_send_restart: got reads=%p done_at=%0d want 0..3 and %0d", rd_idx, done_rel, 2 * N + 1);
      end
   endtask

   task automatic test_random();
      bit to;
      grant_rand = 1'b1; ready_rand = 1'b1;
      for (int it = 0; it < 8; it++) begin
         fill_store(1'b1);
         run_flush(400, 3, to);
         checks++;
         if (to || !reads_ok()) begin
            errors++; $display("FAIL rand%0d_reads: got %p timeout=%0d want 0..%0d", it, rd_idx, to, N - 1);
         end
         checks++;
         if (!wb_ok() || wb_addr.size() != dirty_count()) begin
            errors++; $display("FAIL rand%0d_wb: got %0d requests want %0d matching", it, wb_addr.size(), dirty_count());
         end
         checks++;
         if (!clr_ok() || clr_viol != 0) begin
            errors++; $display("FAIL rand%0d_clr: got %p viol=%0d want dirty indices", it, clr_log, clr_viol);
         end
         checks++;
         if (stab_viol != 0 || ahead_viol != 0 || busy_gap != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL rand%0d_protocol: got unstable=%0d ahead=%0d gap=%0d done=%0d want 0 0 0 1",
                     it, stab_viol, ahead_viol, busy_gap, done_cnt);
         end
      end
      grant_rand = 1'b0; ready_rand = 1'b0;
   endtask

   initial begin
      test_reset();
      test_clean();
      test_dirty_line2();
      test_backpressure();
      test_grant_gap();
      test_restart_ignored();
      test_reset_in_send();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
